noc_out_port: RTL and testbench
===============================

# noc_out_port

Output-port controller for one 4-input NoC switch output. It raises requests toward the port's round-robin arbiter, consumes the arbiter's registered one-hot grant, and locks the output to the winning input for a whole wormhole packet. Flits pass through a one-entry registered output stage with a valid/ready handshake on both sides. It sits directly downstream of the arbiter and drives the outgoing link.

## Interface
- DATA_W, 32, flit payload width.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  4  head-of-FIFO flit valid, one bit per input.
- in_data  in  4*DATA_W  flit payloads; input i occupies [i*DATA_W +: DATA_W].
- in_tail  in  4  flit is the last of its packet.
- in_ready  out  4  pop strobe; a flit transfers on input i when in_valid[i] && in_ready[i].
- arb_req  out  4  requests to the arbiter.
- arb_grant  in  4  registered one-hot grant from the arbiter; reflects arb_req of the previous cycle.
- arb_lock  out  1  high while the port is committed (GNT or XFER).
- out_valid  out  1  output flit valid.
- out_data  out  DATA_W  output flit.
- out_tail  out  1  output flit is a tail.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready.
- owner  out  2  index of the input currently holding the port.
- grant_err  out  1  sticky; set on a grant that is nonzero and not one-hot.

## Operation
- FSM states: ARB, GNT, XFER. Reset state is ARB.
- **ARB**
  - arb_req = in_valid.
  - If in_valid != 0, go to GNT; otherwise stay in ARB.
- **GNT**
  - arb_req = 0, so the arbiter produces no further grant.
  - If arb_grant != 0: latch owner as the index of the lowest set bit and go to XFER.
  - If arb_grant has more than one bit set, also set grant_err.
  - If arb_grant == 0, return to ARB.
- **XFER**
  - arb_req = 0.
  - in_ready[owner] = !out_valid || out_ready. All other in_ready bits are 0.
  - On an accepted flit: out_data ← in_data[owner], out_tail ← in_tail[owner], out_valid ← 1.
  - When out_ready is high and no flit is loaded, out_valid ← 0.
  - Accepting a flit with in_tail[owner] = 1 moves the FSM to ARB on the next cycle.
- in_ready is 0 in ARB and GNT.
- The output register keeps draining (out_valid/out_ready) in every state.
- Input protocol: in_valid, in_data and in_tail hold stable until accepted. If the granted input is not valid, XFER waits indefinitely.
- arb_lock = (state != ARB).
- Reset values: state ARB, owner 0, out_valid 0, out_data 0, out_tail 0, grant_err 0. Hence in_ready, arb_req and arb_lock are all 0 during reset.
- Reset is asynchronous and takes effect mid-packet. Any flit held in the output register is dropped.

## Timing
- Single-flit packet on an idle port, with in_valid rising at cycle 0:
  - cycle 0: arb_req asserted.
  - cycle 1: grant visible, state GNT.
  - cycle 2: XFER, in_ready high, flit accepted.
  - cycle 3: out_valid high.
- Arbitration overhead is 2 cycles per packet.
- Streaming with out_ready held high: one flit per cycle, 1-cycle in→out latency.
- Tail accepted at cycle k: ARB at k+1 with arb_req asserted. The next owner's first flit is accepted at k+3 at the earliest.
- The tail flit in the output register may drain concurrently with the next arbitration.
- Back-pressure: with out_valid high and out_ready low, in_ready is 0. Data is never overwritten.
- A simultaneous unload and load is allowed in the same cycle; out_valid stays high.
- grant_err is sticky until reset.

## Test plan
- **Single input:** input 2 sends a 3-flit packet (D0, D1, D2+tail), out_ready = 1.
  - arb_req = 4'b0100 at cycle 0; owner = 2 from cycle 2.
  - out carries D0, D1, D2 on cycles 3, 4, 5; out_tail only on D2.
- **Contention:** all four inputs send 2-flit packets at once, with the arbiter's last pointer at 0.
  - Packets leave in owner order 0, 1, 2, 3.
  - Exactly one input's in_ready is high at any time.
  - No flits interleave between packets.
- **Back-pressure:** out_ready low for 5 cycles mid-packet.
  - out_data holds steady; in_ready[owner] = 0.
  - Flow resumes the cycle after out_ready rises, with no flit lost or duplicated.
- **Empty/zero grant:**
  - in_valid = 0: state remains ARB and arb_req = 0.
  - Force arb_grant = 0 in GNT: the FSM returns to ARB.
  - Force arb_grant = 4'b0110: owner = 1 and grant_err = 1.
- **Reset mid-packet:** assert reset during XFER with out_valid = 1.
  - Immediately: out_valid = 0, in_ready = 0, arb_lock = 0, owner = 0, grant_err = 0.
  - After release: a fresh packet arbitrates normally.

Source files
------------

// File: rtl/noc_out_port.sv
// +--------------------------------------------------------------------------+
// | noc_out_port - 4-input switch output: wormhole lock + 1-entry out stage |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module noc_out_port #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [3:0]          in_tail,
  output logic [3:0]          in_ready,
  output logic [3:0]          arb_req,
  input  logic [3:0]          arb_grant,
  output logic                arb_lock,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_tail,
  input  logic                out_ready,
  output logic [1:0]          owner,
  output logic                grant_err
);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    GNT  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t              state;
  logic                out_free;
  logic                accept;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_tail;
  logic [1:0]          grant_idx;
  logic                grant_multi;

  assign out_free    = !out_valid || out_ready;
  assign sel_data    = in_data[owner*DATA_W +: DATA_W];
  assign sel_tail    = in_tail[owner];
  assign accept      = |(in_valid & in_ready);
  assign grant_multi = |(arb_grant & (arb_grant - 4'd1));
  assign arb_lock    = (state != ARB);

  // Requests are gated by reset so the arbiter sees nothing while we are held.
  always_comb begin
    arb_req  = 4'b0000;
    in_ready = 4'b0000;
    if (state == ARB && !reset)
      arb_req = in_valid;
    if (state == XFER && out_free)
      in_ready = 4'b0001 << owner;
  end

  always_comb begin
    grant_idx = 2'd0;
    casez (arb_grant)
      4'b???1: grant_idx = 2'd0;
      4'b??10: grant_idx = 2'd1;
      4'b?100: grant_idx = 2'd2;
      4'b1000: grant_idx = 2'd3;
      default: grant_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB;
      owner     <= 2'd0;
      grant_err <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tail  <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (|in_valid)
            state <= GNT;
        end
        GNT: begin
          if (|arb_grant) begin
            owner <= grant_idx;
            state <= XFER;
            if (grant_multi)
              grant_err <= 1'b1;
          end else begin
            state <= ARB;
          end
        end
        XFER: begin
          if (accept && sel_tail)
            state <= ARB;
        end
        default: state <= ARB;
      endcase

      // Output stage drains in every state; a load wins over an unload.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_tail  <= sel_tail;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_noc_out_port.sv
// +--------------------------------------------------------------------------+
// | tb_noc_out_port - directed scoreboard bench with round-robin arbiter     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_noc_out_port;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              tail;
  } flit_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [3:0]          in_valid = '0;
  logic [4*DATA_W-1:0] in_data = '0;
  logic [3:0]          in_tail = '0;
  logic [3:0]          in_ready;
  logic [3:0]          arb_req;
  logic [3:0]          arb_grant = '0;
  logic                arb_lock;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_tail;
  logic                out_ready = 1'b1;
  logic [1:0]          owner;
  logic                grant_err;

  logic       force_en = 1'b0;
  logic [3:0] force_val = '0;
  logic [1:0] ptr = '0;

  flit_t src_q[4][$];
  flit_t exp_q[$];

  int total = 0;
  int passed = 0;

  noc_out_port #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_tail   (in_tail),
    .in_ready  (in_ready),
    .arb_req   (arb_req),
    .arb_grant (arb_grant),
    .arb_lock  (arb_lock),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tail  (out_tail),
    .out_ready (out_ready),
    .owner     (owner),
    .grant_err (grant_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (req[idx] && rr_pick == 4'b0000)
        rr_pick = 4'b0001 << idx;
    end
  endfunction

  task automatic push_flit(input int src, input logic [DATA_W-1:0] d, input logic t, input bit expect_out);
    flit_t f;
    f.data = d;
    f.tail = t;
    src_q[src].push_back(f);
    if (expect_out)
      exp_q.push_back(f);
  endtask

  // Sources, registered arbiter and output scoreboard.
  always begin
    logic [3:0] acc;
    logic [3:0] req;
    logic [3:0] g;
    flit_t      e;
    @(negedge clk);
    #2;
    acc = in_valid & in_ready;
    req = arb_req;
    check("in_ready_owner_only", 64'(in_ready & ~(4'b0001 << owner)), 64'd0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_out_data", 64'(out_data), 64'(e.data));
        check("sb_out_tail", 64'(out_tail), 64'(e.tail));
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      arb_grant = 4'b0000;
      ptr       = 2'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (acc[i] && src_q[i].size() > 0)
          void'(src_q[i].pop_front());
      if (force_en) begin
        arb_grant = force_val;
      end else begin
        g = rr_pick(req, ptr);
        arb_grant = g;
        for (int i = 0; i < 4; i++)
          if (g[i]) ptr = 2'(i + 1);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_data[i*DATA_W +: DATA_W] = src_q[i][0].data;
        in_tail[i] = src_q[i][0].tail;
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*DATA_W +: DATA_W] = '0;
        in_tail[i] = 1'b0;
      end
    end
  end

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = (src_q[0].size() == 0) && (src_q[1].size() == 0) && (src_q[2].size() == 0) &&
             (src_q[3].size() == 0) && (exp_q.size() == 0) && !arb_lock && !out_valid;
    end
    check("idle_reached", 64'(done), 64'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_arb_req", 64'(arb_req), 64'd0);
    check("rst_arb_lock", 64'(arb_lock), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_grant_err", 64'(grant_err), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    reset = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("idle_arb_req", 64'(arb_req), 64'd0);
      check("idle_arb_lock", 64'(arb_lock), 64'd0);
    end

    // Single 3-flit packet on input 2.
    push_flit(2, 32'hA000_0000, 1'b0, 1'b1);
    push_flit(2, 32'hA000_0001, 1'b0, 1'b1);
    push_flit(2, 32'hA000_0002, 1'b1, 1'b1);
    @(negedge clk);
    check("single_c0_arb_req", 64'(arb_req), 64'h4);
    check("single_c0_lock", 64'(arb_lock), 64'd0);
    @(negedge clk);
    check("single_c1_lock", 64'(arb_lock), 64'd1);
    check("single_c1_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("single_c2_owner", 64'(owner), 64'd2);
    check("single_c2_in_ready", 64'(in_ready), 64'h4);
    @(negedge clk);
    check("single_c3_valid", 64'(out_valid), 64'd1);
    check("single_c3_data", 64'(out_data), 64'hA000_0000);
    check("single_c3_tail", 64'(out_tail), 64'd0);
    @(negedge clk);
    check("single_c4_data", 64'(out_data), 64'hA000_0001);
    check("single_c4_tail", 64'(out_tail), 64'd0);
    @(negedge clk);
    check("single_c5_data", 64'(out_data), 64'hA000_0002);
    check("single_c5_tail", 64'(out_tail), 64'd1);
    check("single_c5_lock", 64'(arb_lock), 64'd0);
    wait_idle(50);

    // Zero grant, then a malformed two-hot grant.
    force_en  = 1'b1;
    force_val = 4'b0000;
    push_flit(3, 32'hC000_0003, 1'b1, 1'b0);
    @(negedge clk);
    check("zg_c0_arb_req", 64'(arb_req), 64'h8);
    @(negedge clk);
    check("zg_c1_lock", 64'(arb_lock), 64'd1);
    @(negedge clk);
    check("zg_c2_back_to_arb", 64'(arb_lock), 64'd0);
    check("zg_c2_arb_req", 64'(arb_req), 64'h8);
    force_val = 4'b0110;
    @(negedge clk);
    check("mg_c3_lock", 64'(arb_lock), 64'd1);
    check("mg_c3_err_clear", 64'(grant_err), 64'd0);
    @(negedge clk);
    check("mg_c4_owner", 64'(owner), 64'd1);
    check("mg_c4_grant_err", 64'(grant_err), 64'd1);
    check("mg_c4_in_ready", 64'(in_ready), 64'h2);
    force_en = 1'b0;
    push_flit(1, 32'hC000_0001, 1'b1, 1'b1);
    exp_q.push_back('{data: 32'hC000_0003, tail: 1'b1});
    wait_idle(50);

    // All four inputs contend; round-robin pointer sits at 0 here.
    for (int i = 0; i < 4; i++) begin
      push_flit(i, 32'hB000_0000 | (i << 8), 1'b0, 1'b1);
      push_flit(i, 32'hB000_0001 | (i << 8), 1'b1, 1'b1);
    end
    @(negedge clk);
    check("cont_c0_arb_req", 64'(arb_req), 64'hF);
    wait_idle(100);

    // Back-pressure for 5 cycles mid-packet on input 1.
    for (int k = 0; k < 6; k++)
      push_flit(1, 32'hD100_0000 + k, (k == 5), 1'b1);
    repeat (4) @(negedge clk);
    @(negedge clk);
    check("bp_c4_data", 64'(out_data), 64'hD100_0001);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_data", 64'(out_data), 64'hD100_0001);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_resume_data", 64'(out_data), 64'hD100_0002);
    wait_idle(50);

    // Reset in the middle of a packet.
    check("grant_err_sticky", 64'(grant_err), 64'd1);
    for (int k = 0; k < 4; k++)
      push_flit(0, 32'hE000_0000 + k, (k == 3), 1'b1);
    repeat (4) @(negedge clk);
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    check("mid_pre_lock", 64'(arb_lock), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_lock", 64'(arb_lock), 64'd0);
    check("mid_rst_arb_req", 64'(arb_req), 64'd0);
    check("mid_rst_owner", 64'(owner), 64'd0);
    check("mid_rst_grant_err", 64'(grant_err), 64'd0);
    for (int i = 0; i < 4; i++)
      src_q[i].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    push_flit(2, 32'hF000_0002, 1'b1, 1'b1);
    @(negedge clk);
    check("post_c0_arb_req", 64'(arb_req), 64'h4);
    @(negedge clk);
    @(negedge clk);
    check("post_c2_owner", 64'(owner), 64'd2);
    @(negedge clk);
    check("post_c3_data", 64'(out_data), 64'hF000_0002);
    check("post_c3_tail", 64'(out_tail), 64'd1);
    wait_idle(50);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
